demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//  Parametrised 1-to-N stream demultiplexer: routes a WIDTH-bit word on D to output
//  channel S (or to all channels in broadcast mode) with registered outputs and a
//  per-channel valid/ready handshake. Replaces the combinational 1-to-4 demux where
//  consumers can stall. Sits between a single producer and N independent consumers.
// PARAMETERS
//  WIDTH   8  data word width in bits (>=1)
//  N_OUT   4  number of output channels (2..16, need not be a power of two)
//  SEL_W   derived localparam = $clog2(N_OUT); width of S
// PORTS
//  clk      in   1            rising-edge clock
//  rst_n    in   1            asynchronous active-low reset
//  D        in   WIDTH        input data word
//  D_valid  in   1            producer has a word on D/S/B
//  D_ready  out  1            block can accept the word this cycle
//  S        in   SEL_W        destination channel select
//  B        in   1            broadcast: copy word to every channel
//  Y        out  N_OUT*WIDTH  channel i data = Y[i*WIDTH +: WIDTH]
//  Y_valid  out  N_OUT        channel i holds a word
//  Y_ready  in   N_OUT        consumer i takes its word this cycle
//  err      out  1            one-cycle pulse: word dropped (S >= N_OUT, B=0)
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync release): Y_valid=0, Y=0, err=0. Held words
//    are discarded immediately, including mid-operation; D_ready=0 while rst_n=0.
//  - Each channel has one output register. free[i] = !Y_valid[i] | Y_ready[i].
//  - D_ready (combinational, not dependent on D_valid or D):
//      B=1             -> &free (all channels free or draining)
//      B=0, S< N_OUT   -> free[S]
//      B=0, S>=N_OUT   -> 1 (word is accepted and dropped)
//  - Transfer in = D_valid & D_ready at a rising edge.
//  - Latency 1: word accepted at edge k is on Y slice with Y_valid=1 after edge k.
//    B=1 loads all N_OUT slices and sets all Y_valid bits at the same edge.
//  - Channel pop = Y_valid[i] & Y_ready[i]. Pop and new load on the same edge:
//    Y_valid[i] stays 1, the slice takes the new word (no bubble, no loss).
//    Pop only: Y_valid[i] -> 0 and the slice keeps its old value.
//  - While Y_valid[i]=1 & Y_ready[i]=0, the slice is held bit-stable.
//  - Y_ready[i] while Y_valid[i]=0: ignored.
//  - Out-of-range S (B=0): no channel changes; err=1 for the cycle after the edge,
//    then 0. err is registered. In-range or broadcast transfers never set err.
//  - S is ignored when B=1. No ordering exists between channels; per-channel order
//    matches acceptance order.
//  - Full throughput: one word per cycle when the addressed consumer keeps
//    Y_ready=1.
// TESTING
//  1 Route sweep: Y_ready=4'hF, D=8'hA5, S=0,1,2,3 on consecutive cycles ->
//    Y_valid is one-hot 0001,0010,0100,1000 one cycle later; slice = 8'hA5.
//  2 Stall: Y_ready[2]=0, send 8'h11 then 8'h22 to S=2 -> first held stable,
//    D_ready=0 for the second; raise Y_ready[2] -> 8'h22 lands the same edge as
//    the pop, Y_valid[2] stays 1.
//  3 Broadcast: B=1, D=8'h3C with channel 1 stalled full -> D_ready=0; release
//    channel 1 -> all four slices = 8'h3C and Y_valid=4'hF after one edge.
//  4 Bad select: N_OUT=3, S=3, D_valid=1 -> D_ready=1, Y_valid unchanged, err=1
//    for exactly one cycle.
//  5 Reset mid-flight: Y_valid=4'hF with consumers stalled, assert rst_n=0
//    between edges -> Y_valid=0 and Y=0 immediately, D_ready=0; after release the
//    first word is routed normally.
//  6 Back-to-back: Y_ready=1 on channel 0 and 20 consecutive words to S=0 ->
//    one word out per cycle, in order, no drops.

Source files
------------

// File: rtl/demux_stream_if.sv
// Stream demultiplexer bus: one producer side (D/S/B with valid/ready) and
// N_OUT consumer channels packed into Y/Y_valid/Y_ready, plus drop error pulse.
interface demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
);
    logic [WIDTH-1:0]       D;
    logic                   D_valid;
    logic                   D_ready;
    logic [SEL_W-1:0]       S;
    logic                   B;
    logic [N_OUT*WIDTH-1:0] Y;
    logic [N_OUT-1:0]       Y_valid;
    logic [N_OUT-1:0]       Y_ready;
    logic                   err;

    // Producer/consumer environment view
    modport master (
        output D, D_valid, S, B, Y_ready,
        input  D_ready, Y, Y_valid, err
    );

    // Demultiplexer view
    modport slave (
        input  D, D_valid, S, B, Y_ready,
        output D_ready, Y, Y_valid, err
    );
endinterface

// File: rtl/demux_stream.sv
// 1-to-N_OUT stream demultiplexer with one registered output slot per channel,
// per-channel valid/ready handshake, broadcast mode and a dropped-word error pulse.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_if.slave  bus
);
    localparam int SEL_W = $clog2(N_OUT);
    // One extra bit so N_OUT itself is representable for the range compare
    localparam logic [SEL_W:0] N_LIM = N_OUT[SEL_W:0];

    logic [WIDTH-1:0] y_data [N_OUT];
    logic [N_OUT-1:0] y_valid;
    logic             err_q;

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] pop;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             ready;
    logic             xfer;

    // Channel slot availability, pops and the input-side ready decision
    always_comb begin
        free   = ~y_valid | bus.Y_ready;
        pop    = y_valid & bus.Y_ready;
        sel_ok = ({1'b0, bus.S} < N_LIM);
        ready  = 1'b0;
        if (rst_n) begin
            if (bus.B)
                ready = &free;
            else if (sel_ok)
                ready = free[bus.S];
            else
                ready = 1'b1;
        end
        xfer = bus.D_valid & ready;
    end

    // Per-channel load strobes: broadcast hits all, otherwise the selected one
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            load[i] = xfer & (bus.B | (sel_ok & (bus.S == SEL_W'(i))));
        end
    end

    // Channel output registers; a load on the same edge as a pop keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                y_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (load[i]) begin
                    y_data[i]  <= bus.D;
                    y_valid[i] <= 1'b1;
                end else if (pop[i]) begin
                    y_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Error pulse for a word accepted with an out-of-range select and no broadcast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= xfer & ~bus.B & ~sel_ok;
    end

    // Pack channel slots onto the flat output bus
    always_comb begin
        bus.Y = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            bus.Y[i*WIDTH +: WIDTH] = y_data[i];
        end
        bus.Y_valid = y_valid;
        bus.D_ready = ready;
        bus.err     = err_q;
    end
endmodule

// File: tb/tb_demux_stream.sv
// Directed testbench for demux_stream: a 4-channel instance for routing, stall,
// broadcast, reset and throughput cases, and a 3-channel instance for bad selects.
module tb_demux_stream;
    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    demux_stream_if #(.WIDTH(8), .N_OUT(4)) a_if ();
    demux_stream_if #(.WIDTH(8), .N_OUT(3)) b_if ();

    demux_stream #(.WIDTH(8), .N_OUT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    demux_stream #(.WIDTH(8), .N_OUT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled off the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice_a(input int ch);
        logic [31:0] y;
        y = a_if.Y;
        return y[ch*8 +: 8];
    endfunction

    function automatic logic [7:0] slice_b(input int ch);
        logic [23:0] y;
        y = b_if.Y;
        return y[ch*8 +: 8];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a_if.D = '0; a_if.D_valid = 1'b0; a_if.S = '0; a_if.B = 1'b0; a_if.Y_ready = '0;
        b_if.D = '0; b_if.D_valid = 1'b0; b_if.S = '0; b_if.B = 1'b0; b_if.Y_ready = '0;

        // Reset state
        step();
        step();
        check("rst_yvalid", 64'(a_if.Y_valid), 64'h0);
        check("rst_y",      64'(a_if.Y), 64'h0);
        check("rst_err",    64'(a_if.err), 64'h0);
        a_if.Y_ready = 4'hF;
        #1;
        check("rst_dready", 64'(a_if.D_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: route sweep
        a_if.Y_ready = 4'hF;
        a_if.D = 8'hA5;
        a_if.D_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.S = 2'(i);
            step();
            check("sweep_valid", 64'(a_if.Y_valid), 64'(4'b0001 << i));
            check("sweep_data",  64'(slice_a(i)), 64'hA5);
        end
        a_if.D_valid = 1'b0;
        step();
        check("sweep_drain", 64'(a_if.Y_valid), 64'h0);

        // 2: stall on channel 2
        a_if.Y_ready = 4'b1011;
        a_if.S = 2'd2;
        a_if.D = 8'h11;
        a_if.D_valid = 1'b1;
        #1;
        check("stall_rdy0", 64'(a_if.D_ready), 64'h1);
        step();
        check("stall_v1", 64'(a_if.Y_valid), 64'h4);
        check("stall_d1", 64'(slice_a(2)), 64'h11);
        a_if.D = 8'h22;
        #1;
        check("stall_rdy1", 64'(a_if.D_ready), 64'h0);
        step();
        check("stall_hold_d", 64'(slice_a(2)), 64'h11);
        check("stall_hold_v", 64'(a_if.Y_valid), 64'h4);
        a_if.Y_ready = 4'hF;
        #1;
        check("stall_rdy2", 64'(a_if.D_ready), 64'h1);
        step();
        check("stall_v2", 64'(a_if.Y_valid), 64'h4);
        check("stall_d2", 64'(slice_a(2)), 64'h22);
        a_if.D_valid = 1'b0;
        step();
        check("stall_drain", 64'(a_if.Y_valid), 64'h0);

        // 3: broadcast blocked by a full channel 1
        a_if.Y_ready = 4'b1101;
        a_if.S = 2'd1;
        a_if.D = 8'h77;
        a_if.D_valid = 1'b1;
        step();
        check("bc_fill", 64'(a_if.Y_valid), 64'h2);
        a_if.B = 1'b1;
        a_if.S = 2'd3;
        a_if.D = 8'h3C;
        #1;
        check("bc_rdy0", 64'(a_if.D_ready), 64'h0);
        step();
        check("bc_blk_v", 64'(a_if.Y_valid), 64'h2);
        check("bc_blk_d", 64'(slice_a(1)), 64'h77);
        a_if.Y_ready = 4'hF;
        #1;
        check("bc_rdy1", 64'(a_if.D_ready), 64'h1);
        step();
        check("bc_valid", 64'(a_if.Y_valid), 64'hF);
        check("bc_data",  64'(a_if.Y), 64'h3C3C3C3C);
        check("bc_err",   64'(a_if.err), 64'h0);
        a_if.D_valid = 1'b0;
        a_if.B = 1'b0;
        step();
        check("bc_drain", 64'(a_if.Y_valid), 64'h0);

        // 4: out-of-range select on the 3-channel instance
        b_if.Y_ready = 3'b000;
        b_if.S = 2'd0;
        b_if.D = 8'h81;
        b_if.D_valid = 1'b1;
        step();
        check("bad_pre_v",   64'(b_if.Y_valid), 64'h1);
        check("bad_pre_err", 64'(b_if.err), 64'h0);
        b_if.S = 2'd3;
        b_if.D = 8'h99;
        #1;
        check("bad_rdy", 64'(b_if.D_ready), 64'h1);
        step();
        check("bad_v",   64'(b_if.Y_valid), 64'h1);
        check("bad_d",   64'(slice_b(0)), 64'h81);
        check("bad_err", 64'(b_if.err), 64'h1);
        b_if.D_valid = 1'b0;
        step();
        check("bad_err_clr", 64'(b_if.err), 64'h0);
        check("bad_v2",      64'(b_if.Y_valid), 64'h1);

        // 5: reset while every channel is full and stalled
        a_if.Y_ready = 4'h0;
        a_if.B = 1'b1;
        a_if.D = 8'h5A;
        a_if.D_valid = 1'b1;
        step();
        check("rm_full", 64'(a_if.Y_valid), 64'hF);
        a_if.D_valid = 1'b0;
        a_if.B = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_v",   64'(a_if.Y_valid), 64'h0);
        check("rm_y",   64'(a_if.Y), 64'h0);
        check("rm_rdy", 64'(a_if.D_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a_if.Y_ready = 4'hF;
        a_if.S = 2'd2;
        a_if.D = 8'hC3;
        a_if.D_valid = 1'b1;
        step();
        check("rm_after_v", 64'(a_if.Y_valid), 64'h4);
        check("rm_after_d", 64'(slice_a(2)), 64'hC3);
        a_if.D_valid = 1'b0;
        step();

        // 6: back-to-back stream into channel 0
        a_if.Y_ready = 4'h1;
        a_if.S = 2'd0;
        a_if.D_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_if.D = 8'(8'h40 + i);
            #1;
            check("b2b_rdy", 64'(a_if.D_ready), 64'h1);
            step();
            check("b2b_v", 64'(a_if.Y_valid), 64'h1);
            check("b2b_d", 64'(slice_a(0)), 64'(8'(8'h40 + i)));
        end
        a_if.D_valid = 1'b0;
        step();
        check("b2b_drain", 64'(a_if.Y_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
